// File: rtl/mbi5153_rx.sv
// Panel-side receiver for the MBI5153 grey-scale stream: oversamples DCLK/LATCH/lanes, rebuilds the
// daisy-chain shift registers and writes each data latch into the line RAM in sender layout.
module mbi5153_rx #(
    parameter int NUM_IC_CHAIN    = 4,
    parameter int NUM_CH_IC       = 16,
    parameter int IC_WORD_LENGTH  = 16,
    parameter int NUMBER_OF_LANES = 3,
    parameter int ADDR_WIDTH      = $clog2(NUM_IC_CHAIN * NUM_CH_IC)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_dclk,
    input  logic                         i_latch,
    input  logic [NUMBER_OF_LANES-1:0]   i_r,
    input  logic [NUMBER_OF_LANES-1:0]   i_g,
    input  logic [NUMBER_OF_LANES-1:0]   i_b,
    output logic                         o_wr_en,
    output logic [ADDR_WIDTH-1:0]        o_wr_addr,
    output logic [23:0]                  o_wr_data0,
    output logic [23:0]                  o_wr_data1,
    output logic [23:0]                  o_wr_data2,
    output logic [$clog2(NUM_CH_IC)-1:0] o_ch_num,
    output logic                         o_vsync_stb,
    output logic                         o_cmd_stb,
    output logic [3:0]                   o_cmd_len,
    output logic                         o_busy,
    output logic                         o_frame_err,
    output logic                         o_overrun
);

    localparam int CHAIN_W = NUM_IC_CHAIN * IC_WORD_LENGTH;
    localparam int CNT_W   = $clog2(CHAIN_W) + 1;
    localparam int K_W     = (NUM_IC_CHAIN > 1) ? $clog2(NUM_IC_CHAIN) : 1;
    localparam int CH_W    = $clog2(NUM_CH_IC);

    typedef enum logic {
        StIdle,
        StWrite
    } state_t;

    // Input synchronizers (no reset: they only carry pin levels)
    logic                       r_dclk_s1, r_dclk_s2, r_dclk_h;
    logic                       r_lat_s1, r_lat_s2, r_lat_h;
    logic [NUMBER_OF_LANES-1:0] r_r_s1, r_r_s2;
    logic [NUMBER_OF_LANES-1:0] r_g_s1, r_g_s2;
    logic [NUMBER_OF_LANES-1:0] r_b_s1, r_b_s2;
    logic                       r_armed;

    logic [CHAIN_W-1:0] r_chain_r [NUMBER_OF_LANES];
    logic [CHAIN_W-1:0] r_chain_g [NUMBER_OF_LANES];
    logic [CHAIN_W-1:0] r_chain_b [NUMBER_OF_LANES];
    logic [CHAIN_W-1:0] r_hold_r  [NUMBER_OF_LANES];
    logic [CHAIN_W-1:0] r_hold_g  [NUMBER_OF_LANES];
    logic [CHAIN_W-1:0] r_hold_b  [NUMBER_OF_LANES];

    logic [CNT_W-1:0] r_bit_cnt;
    logic [3:0]       r_lat_cnt;
    logic [CH_W-1:0]  r_ch_num;
    logic [CH_W-1:0]  r_ch_lat;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_vsync_stb;
    logic             r_cmd_stb;
    logic [3:0]       r_cmd_len;
    logic [K_W-1:0]   r_k;
    state_t           r_state;
    state_t           w_state_next;

    logic w_dclk_rise;
    logic w_lat_fall;
    logic w_data_lat;
    logic w_vsync;
    logic w_cmd;
    logic w_last_k;
    logic [23:0] w_lane_data [3];

    always_ff @(posedge i_clk) begin
        r_dclk_s1 <= i_dclk;
        r_dclk_s2 <= r_dclk_s1;
        r_dclk_h  <= r_dclk_s2;
        r_lat_s1  <= i_latch;
        r_lat_s2  <= r_lat_s1;
        r_lat_h   <= r_lat_s2;
        r_r_s1    <= i_r;
        r_r_s2    <= r_r_s1;
        r_g_s1    <= i_g;
        r_g_s2    <= r_g_s1;
        r_b_s1    <= i_b;
        r_b_s2    <= r_b_s1;
    end

    // Edges are masked for one cycle after reset so the history flops settle on the live level.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_armed <= 1'b0;
        else         r_armed <= 1'b1;
    end

    assign w_dclk_rise = r_armed & r_dclk_s2 & ~r_dclk_h;
    assign w_lat_fall  = r_armed & ~r_lat_s2 & r_lat_h;
    assign w_data_lat  = w_lat_fall && (r_lat_cnt == 4'd1);
    assign w_vsync     = w_lat_fall && (r_lat_cnt == 4'd3);
    assign w_cmd       = w_lat_fall && (r_lat_cnt != 4'd0) && (r_lat_cnt != 4'd1)
                         && (r_lat_cnt != 4'd3);
    assign w_last_k    = (r_k == K_W'(NUM_IC_CHAIN - 1));

    // Snapshot uses the pre-shift chain when a DCLK rise coincides with the LATCH fall.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int l = 0; l < NUMBER_OF_LANES; l++) begin
                r_chain_r[l] <= '0;
                r_chain_g[l] <= '0;
                r_chain_b[l] <= '0;
                r_hold_r[l]  <= '0;
                r_hold_g[l]  <= '0;
                r_hold_b[l]  <= '0;
            end
        end else begin
            for (int l = 0; l < NUMBER_OF_LANES; l++) begin
                if (w_data_lat) begin
                    r_hold_r[l] <= r_chain_r[l];
                    r_hold_g[l] <= r_chain_g[l];
                    r_hold_b[l] <= r_chain_b[l];
                end
                if (w_dclk_rise) begin
                    r_chain_r[l] <= {r_chain_r[l][CHAIN_W-2:0], r_r_s2[l]};
                    r_chain_g[l] <= {r_chain_g[l][CHAIN_W-2:0], r_g_s2[l]};
                    r_chain_b[l] <= {r_chain_b[l][CHAIN_W-2:0], r_b_s2[l]};
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bit_cnt <= '0;
            r_lat_cnt <= '0;
        end else if (w_lat_fall) begin
            r_bit_cnt <= w_dclk_rise ? CNT_W'(1) : '0;
            r_lat_cnt <= '0;
        end else if (w_dclk_rise) begin
            if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_lat_s2 && (r_lat_cnt != 4'hF)) r_lat_cnt <= r_lat_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ch_num    <= '0;
            r_ch_lat    <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_vsync_stb <= 1'b0;
            r_cmd_stb   <= 1'b0;
            r_cmd_len   <= '0;
        end else begin
            r_vsync_stb <= w_vsync;
            r_cmd_stb   <= w_cmd;
            if (w_vsync || w_cmd) r_cmd_len <= r_lat_cnt;
            if (w_data_lat) begin
                r_ch_lat <= r_ch_num;
                r_ch_num <= (r_ch_num == CH_W'(NUM_CH_IC - 1)) ? '0 : r_ch_num + 1'b1;
                if (r_bit_cnt != CNT_W'(CHAIN_W)) r_frame_err <= 1'b1;
                if (r_state == StWrite) r_overrun <= 1'b1;
            end else if (w_vsync) begin
                r_ch_num <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_k     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_data_lat || r_state != StWrite || w_last_k) r_k <= '0;
            else                                           r_k <= r_k + 1'b1;
        end
    end

    // A data latch during readout restarts it with the fresh snapshot.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_data_lat) w_state_next = StWrite;
            StWrite: if (!w_data_lat && w_last_k) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // k = 0 is the farthest IC, i.e. the oldest word in the chain.
    function automatic logic [7:0] top_byte(input logic [CHAIN_W-1:0] hold,
                                            input logic [K_W-1:0]     k);
        return 8'(hold >> ((NUM_IC_CHAIN - int'(k)) * IC_WORD_LENGTH - 8));
    endfunction

    for (genvar l = 0; l < 3; l++) begin : g_lane
        if (l < NUMBER_OF_LANES) begin : g_used
            assign w_lane_data[l] = {top_byte(r_hold_r[l], r_k), top_byte(r_hold_g[l], r_k),
                                     top_byte(r_hold_b[l], r_k)};
        end else begin : g_unused
            assign w_lane_data[l] = '0;
        end
    end

    assign o_wr_en     = (r_state == StWrite);
    assign o_busy      = (r_state == StWrite);
    assign o_wr_addr   = ADDR_WIDTH'(r_ch_lat) + ADDR_WIDTH'(r_k) * ADDR_WIDTH'(NUM_CH_IC);
    assign o_wr_data0  = w_lane_data[0];
    assign o_wr_data1  = w_lane_data[1];
    assign o_wr_data2  = w_lane_data[2];
    assign o_ch_num    = r_ch_num;
    assign o_vsync_stb = r_vsync_stb;
    assign o_cmd_stb   = r_cmd_stb;
    assign o_cmd_len   = r_cmd_len;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_mbi5153_rx.sv
// Directed bench for mbi5153_rx: a 4x16 instance plus a 16x8 instance sharing the same pins.
module tb_mbi5153_rx;

    logic       clk = 1'b0;
    logic       rst, dclk, lat;
    logic [2:0] r, g, b;

    logic        wr_en, vsync_stb, cmd_stb, busy, frame_err, overrun;
    logic [5:0]  wr_addr;
    logic [23:0] wr_data0, wr_data1, wr_data2;
    logic [3:0]  ch_num, cmd_len;

    logic        wr_en2, vsync_stb2, cmd_stb2, busy2, frame_err2, overrun2;
    logic [7:0]  wr_addr2;
    logic [23:0] wr_data0_2, wr_data1_2, wr_data2_2;
    logic [3:0]  ch_num2, cmd_len2;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0]  wq_addr [$];
    logic [23:0] wq_data [$];
    logic [7:0]  w2_addr [$];
    int          vs_cnt = 0, cmd_cnt = 0, busy_cnt = 0;
    logic [3:0]  vs_len = 0, vs_ch = 0, cmd_len_seen = 0;

    always #5 clk = ~clk;

    mbi5153_rx u_dut (
        .i_clk(clk), .i_reset(rst), .i_dclk(dclk), .i_latch(lat), .i_r(r), .i_g(g), .i_b(b),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data0(wr_data0), .o_wr_data1(wr_data1),
        .o_wr_data2(wr_data2), .o_ch_num(ch_num), .o_vsync_stb(vsync_stb), .o_cmd_stb(cmd_stb),
        .o_cmd_len(cmd_len), .o_busy(busy), .o_frame_err(frame_err), .o_overrun(overrun)
    );

    mbi5153_rx #(
        .NUM_IC_CHAIN(16),
        .IC_WORD_LENGTH(8)
    ) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_dclk(dclk), .i_latch(lat), .i_r(r), .i_g(g), .i_b(b),
        .o_wr_en(wr_en2), .o_wr_addr(wr_addr2), .o_wr_data0(wr_data0_2),
        .o_wr_data1(wr_data1_2), .o_wr_data2(wr_data2_2), .o_ch_num(ch_num2),
        .o_vsync_stb(vsync_stb2), .o_cmd_stb(cmd_stb2), .o_cmd_len(cmd_len2), .o_busy(busy2),
        .o_frame_err(frame_err2), .o_overrun(overrun2)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data0);
        end
        if (wr_en2) w2_addr.push_back(wr_addr2);
        if (busy) busy_cnt++;
        if (vsync_stb) begin
            vs_cnt++;
            vs_len = cmd_len;
            vs_ch  = ch_num;
        end
        if (cmd_stb) begin
            cmd_cnt++;
            cmd_len_seen = cmd_len;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic rv, input logic lat_lo, input logic lat_hi);
        r    = {2'b00, rv};
        g    = 3'b000;
        b    = 3'b000;
        lat  = lat_lo;
        dclk = 1'b0;
        repeat (3) @(negedge clk);
        lat  = lat_hi;
        dclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic idle(input int n);
        lat  = 1'b0;
        dclk = 1'b0;
        r    = 3'b000;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] rd, input int nbits, input int nlat);
        logic l;
        for (int i = 0; i < nbits; i++) begin
            l = (i >= nbits - nlat);
            send_bit(rd[63-i], l, l);
        end
        idle(14);
    endtask

    task automatic do_reset(input bit chk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if (chk) begin
            check_eq("rst_wr_en", 32'(wr_en), 32'd0);
            check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
            check_eq("rst_wr_data0", 32'(wr_data0), 32'd0);
            check_eq("rst_ch_num", 32'(ch_num), 32'd0);
            check_eq("rst_frame_err", 32'(frame_err), 32'd0);
            check_eq("rst_overrun", 32'(overrun), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_strobes", 32'({vsync_stb, cmd_stb, cmd_len}), 32'd0);
            check_eq("rst_dut2", 32'({wr_en2, overrun2, frame_err2, ch_num2}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int first, input logic [31:0] bytes,
                                input int base);
        logic [31:0] ga, gd;
        for (int k = 0; k < 4; k++) begin
            if (first + k < wq_addr.size()) begin
                ga = 32'(wq_addr[first+k]);
                gd = 32'(wq_data[first+k]);
            end else begin
                ga = 32'hDEAD_BEEF;
                gd = 32'hDEAD_BEEF;
            end
            check_eq({tag, "_addr"}, ga, 32'(base + 16 * k));
            check_eq({tag, "_data"}, gd, 32'({bytes[31-8*k -: 8], 16'h0000}));
        end
    endtask

    initial begin
        int q0, q2, b0, v0, c0;
        rst  = 1'b1;
        dclk = 1'b0;
        lat  = 1'b0;
        r    = '0;
        g    = '0;
        b    = '0;
        @(negedge clk);
        do_reset(1'b1);

        // Basic 64-DCLK data frame
        q0 = wq_addr.size();
        b0 = busy_cnt;
        send_frame(64'hAB00_CD00_1200_3400, 64, 1);
        check_eq("t1_nwr", 32'(wq_addr.size() - q0), 32'd4);
        check_writes("t1", q0, 32'hABCD_1234, 0);
        check_eq("t1_ch", 32'(ch_num), 32'd1);
        check_eq("t1_ferr", 32'(frame_err), 32'd0);
        check_eq("t1_busy_cycles", 32'(busy_cnt - b0), 32'd4);

        // Channel wrap after 16 data latches
        for (int f = 1; f < 16; f++) begin
            q0 = wq_addr.size();
            send_frame(64'h0102_0304_0506_0708, 64, 1);
        end
        check_writes("t2_f16", q0, 32'h0103_0507, 15);
        check_eq("t2_wrap_ch", 32'(ch_num), 32'd0);
        send_frame(64'h0102_0304_0506_0708, 64, 1);
        check_eq("t2_ch_after17", 32'(ch_num), 32'd1);

        // Width-5 command: strobe only
        q0 = wq_addr.size();
        c0 = cmd_cnt;
        v0 = vs_cnt;
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 5, 5);
        check_eq("t4_cmd_cnt", 32'(cmd_cnt - c0), 32'd1);
        check_eq("t4_cmd_len", 32'(cmd_len_seen), 32'd5);
        check_eq("t4_nwr", 32'(wq_addr.size() - q0), 32'd0);
        check_eq("t4_ch", 32'(ch_num), 32'd1);
        check_eq("t4_no_vsync", 32'(vs_cnt - v0), 32'd0);

        // Vsync clears the channel
        c0 = cmd_cnt;
        v0 = vs_cnt;
        send_frame(64'h0, 3, 3);
        check_eq("t2_vs_cnt", 32'(vs_cnt - v0), 32'd1);
        check_eq("t2_vs_len", 32'(vs_len), 32'd3);
        check_eq("t2_vs_ch", 32'(vs_ch), 32'd0);
        check_eq("t2_vs_no_cmd", 32'(cmd_cnt - c0), 32'd0);

        // Short frame: sticky frame error, writes still issued
        q0 = wq_addr.size();
        send_frame(64'hAAAA_AAAA_AAAA_AAAA, 48, 1);
        check_eq("t3_ferr", 32'(frame_err), 32'd1);
        check_eq("t3_nwr", 32'(wq_addr.size() - q0), 32'd4);
        send_frame(64'h0102_0304_0506_0708, 64, 1);
        check_eq("t3_ferr_sticky", 32'(frame_err), 32'd1);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 30; i++) send_bit(1'b1, 1'b0, 1'b0);
        do_reset(1'b1);
        q0 = wq_addr.size();
        send_frame(64'h5A00_6B00_7C00_8D00, 64, 1);
        check_eq("t6_nwr", 32'(wq_addr.size() - q0), 32'd4);
        check_writes("t6", q0, 32'h5A6B_7C8D, 0);
        check_eq("t6_ferr", 32'(frame_err), 32'd0);

        // DCLK rise coincident with LATCH fall: pre-shift snapshot, bit counts for next frame
        begin
            logic [63:0] pf, qf;
            pf = 64'h1122_3344_5566_7788;
            qf = 64'hA0B0_C0D0_E0F0_0102;
            q0 = wq_addr.size();
            for (int i = 0; i < 64; i++) send_bit(pf[63-i], i == 63, i == 63);
            send_bit(qf[63], 1'b1, 1'b0);
            for (int i = 1; i < 64; i++) send_bit(qf[63-i], i == 63, i == 63);
            idle(14);
            check_eq("t8_nwr", 32'(wq_addr.size() - q0), 32'd8);
            check_writes("t8p", q0, 32'h1133_5577, 1);
            check_writes("t8q", q0 + 4, 32'hA0C0_E001, 2);
            check_eq("t8_ferr", 32'(frame_err), 32'd0);
        end

        // Overrun on the 16x8 instance: second latch arrives at k = 11
        do_reset(1'b0);
        q2 = w2_addr.size();
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        idle(30);
        check_eq("t7_overrun", 32'(overrun2), 32'd1);
        check_eq("t7_nwr", 32'(w2_addr.size() - q2), 32'd28);
        if (w2_addr.size() - q2 >= 28) begin
            check_eq("t7_first_addr", 32'(w2_addr[q2]), 32'd0);
            check_eq("t7_abort_addr", 32'(w2_addr[q2+11]), 32'd176);
            check_eq("t7_restart_addr", 32'(w2_addr[q2+12]), 32'd1);
            check_eq("t7_last_addr", 32'(w2_addr[q2+27]), 32'd241);
        end
        check_eq("t7_ch2", 32'(ch_num2), 32'd2);
        check_eq("t7_dut1_no_overrun", 32'(overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mbi5153_rx.md
Name: mbi5153_rx

Overview:
- Panel-side receiver for the MBI5153 serial grey-scale stream: the inverse of the line sender.
- Oversamples DCLK, LATCH and the R/G/B lanes in the system clock domain and rebuilds the daisy-chain shift registers.
- Decodes LATCH width into commands; on each data latch, writes the captured per-IC words into a line RAM using the same address layout the sender reads from.
- Used for FPGA loopback self-test and as a chained-panel input stage.

Parameters:
- NUM_IC_CHAIN, 4, number of ICs in the chain
- NUM_CH_IC, 16, channels per IC
- IC_WORD_LENGTH, 16, bits per GS word (8 allowed for debug)
- NUMBER_OF_LANES, 3, RGB lanes (1..3)
- ADDR_WIDTH, $clog2(NUM_IC_CHAIN*NUM_CH_IC), line-RAM address width

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- DCLK  in  1  serial clock, asynchronous to CLK, frequency ≤ CLK/4, high and low phases ≥ 2 CLK each
- LATCH  in  1  command strobe
- R, G, B  in  NUMBER_OF_LANES each  serial data lanes
- WR_EN  out  1  line-RAM write strobe
- WR_ADDR  out  ADDR_WIDTH  write address
- WR_DATA0, WR_DATA1, WR_DATA2  out  24 each  {R[15:8],G[15:8],B[15:8]} of lanes 0..2; unused lanes drive 0
- CH_NUM  out  $clog2(NUM_CH_IC)  channel index of the next data latch
- VSYNC_STB  out  1  one-cycle pulse on a Vsync command
- CMD_STB  out  1  one-cycle pulse on any other non-zero command
- CMD_LEN  out  4  LATCH width in DCLKs, saturating at 15, valid with CMD_STB or VSYNC_STB
- BUSY  out  1  readout in progress
- FRAME_ERR  out  1  sticky: a data latch arrived with a DCLK count ≠ NUM_IC_CHAIN*IC_WORD_LENGTH
- OVERRUN  out  1  sticky: a data latch arrived while BUSY

Behaviour:
- Reset: all outputs are 0; chain registers, counters and sticky flags are cleared. A reset mid-frame discards the partial frame. Input edges are ignored during reset; the DCLK/LATCH previous-state registers load the current synchronized level on the first cycle after reset, so no false edge is seen.
- Input capture: DCLK, LATCH and every lane pass a 2-flop synchronizer of equal depth, plus one history flop on DCLK and LATCH.
  - DCLK rise = sync high and history low.
  - On a DCLK rise, each lane/colour chain register (NUM_IC_CHAIN*IC_WORD_LENGTH bits) shifts left, with the lane bit entering at the LSB.
  - bit_cnt increments, saturating at all-ones.
  - If LATCH sync is 1, lat_cnt increments, saturating at 15.
- Command decode occurs on the LATCH fall (sync low, history high); lat_cnt and bit_cnt are then cleared.
  - lat_cnt = 1 is a data latch. Snapshot the chains into holding registers, start readout, and set FRAME_ERR if bit_cnt ≠ NUM_IC_CHAIN*IC_WORD_LENGTH. CH_NUM increments, wrapping NUM_CH_IC-1 → 0.
  - lat_cnt = 3 is Vsync. Pulse VSYNC_STB with CMD_LEN = 3 and clear CH_NUM.
  - Any other non-zero lat_cnt pulses CMD_STB with CMD_LEN = lat_cnt. There is no write, and CH_NUM is unchanged.
  - lat_cnt = 0 (LATCH pulse with no DCLK) is ignored.
- If a DCLK rise and a LATCH fall occur in the same cycle:
  - the snapshot takes the pre-shift chain value;
  - the new bit is shifted after the snapshot and counts as bit 1 of the next frame (bit_cnt becomes 1, not 0).
- Readout uses two states, IDLE and WRITE, and starts the cycle after the decode.
  - WRITE lasts NUM_IC_CHAIN cycles, with k = 0..NUM_IC_CHAIN-1.
  - WR_EN = 1 throughout, and BUSY = 1.
  - k = 0 is the first word shifted in, i.e. the farthest IC: holding bits [(NUM_IC_CHAIN-k)*W-1 -: W], where W = IC_WORD_LENGTH.
  - WR_ADDR = CH_NUM_latched + k*NUM_CH_IC, where CH_NUM_latched is the value before the increment.
  - When IC_WORD_LENGTH = 8, WR_DATA takes the whole 8-bit word per colour.
  - After k = NUM_IC_CHAIN-1, return to IDLE.
- A data latch while BUSY sets OVERRUN, aborts the current readout and restarts at k = 0 with the new snapshot.
- Decode-to-first-WR_EN latency is 1 CLK; LATCH-pin fall to decode is 3 CLK.

Test Plan:
- 64 DCLKs with words 0xAB00, 0xCD00, 0x1200, 0x3400 on R0, LATCH high on DCLK 64 -> WR_EN for 4 cycles; WR_ADDR 0, 16, 32, 48; WR_DATA0[23:16] = AB, CD, 12, 34; CH_NUM 0 → 1; FRAME_ERR = 0.
- 16 data-latch frames, then a 3-DCLK LATCH -> CH_NUM wraps 15 → 0 after frame 16; VSYNC_STB pulses with CMD_LEN = 3 and CH_NUM = 0.
- Frame of 48 DCLKs, then a data latch -> FRAME_ERR = 1 and 4 writes still issued; FRAME_ERR stays 1 until RESET.
- LATCH width 5 DCLKs -> CMD_STB pulse with CMD_LEN = 5, no WR_EN, CH_NUM unchanged.
- NUM_IC_CHAIN = 16, W = 8: two 1-DCLK latches 2 DCLK periods apart -> OVERRUN = 1; second readout runs k = 0..15 at CH_NUM = 1.
- RESET asserted after 30 DCLKs, then a clean 64-DCLK frame -> outputs 0 during reset; data written matches only the post-reset frame at addresses 0, 16, 32, 48.
